// File: rtl/block_state_ram_pkg.sv
// block_state_ram_pkg
//   Shared definitions for the breakout block-state table:
//   default geometry, alive-bit position helper and the load FSM states.
package block_state_ram_pkg;

   localparam int unsigned DEFAULT_WIDTH      = 10;
   localparam int unsigned DEFAULT_ADDR_WIDTH = 5;

   // The alive flag sits in the top bit of every ROM / table entry.
   function automatic int unsigned alive_bit(input int unsigned width);
      return width - 1;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } load_state_t;

endpackage

// File: rtl/block_state_ram_load_fsm.sv
// block_load_fsm
//   Sequences the position-ROM address during a level load and produces
//   capture strobes for the table, compensating for the one-clock ROM latency.
// Ports:
//   clk, reset     : rising-edge clock, asynchronous active-high reset
//   i_start        : load request (honoured only in IDLE)
//   o_rom_addr     : address issued to the ROM
//   o_clear        : clear alive vector / count (load accepted this cycle)
//   o_cap_valid    : rom data present this cycle belongs to o_cap_addr
//   o_cap_addr     : table index to write with the current rom data
//   o_busy         : FETCH, DRAIN or DONE
//   o_done         : one-cycle load-complete pulse
module block_load_fsm
   import block_state_ram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_start,
   output logic [ADDR_WIDTH-1:0] o_rom_addr,
   output logic                  o_clear,
   output logic                  o_cap_valid,
   output logic [ADDR_WIDTH-1:0] o_cap_addr,
   output logic                  o_busy,
   output logic                  o_done
);

   load_state_t           r_state;
   load_state_t           w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_rom_addr;
   logic [ADDR_WIDTH-1:0] w_rom_addr_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_rom_addr <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rom_addr <= w_rom_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_rom_addr_nxt = r_rom_addr;
      o_clear        = 1'b0;
      o_cap_valid    = 1'b0;
      o_cap_addr     = r_rom_addr;
      o_busy         = 1'b1;
      o_done         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            o_busy = 1'b0;
            if (i_start) begin
               w_state_nxt    = ST_FETCH;
               w_rom_addr_nxt = '0;
               o_clear        = 1'b1;
            end
         end
         ST_FETCH: begin
            // rom_q now holds the word for the address issued last cycle;
            // on the first FETCH cycle (address 0 just issued) there is none.
            o_cap_valid = (r_rom_addr != '0);
            o_cap_addr  = r_rom_addr - ADDR_WIDTH'(1);
            if (r_rom_addr == '1) begin
               w_state_nxt = ST_DRAIN;
            end else begin
               w_rom_addr_nxt = r_rom_addr + ADDR_WIDTH'(1);
            end
         end
         ST_DRAIN: begin
            // Last address was held, so rom_q is its word.
            o_cap_valid = 1'b1;
            o_cap_addr  = r_rom_addr;
            w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            o_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign o_rom_addr = r_rom_addr;

endmodule

// File: rtl/block_state_ram.sv
// block_state_ram
//   Writable copy of the level's block table. Loaded from the position ROM on
//   request, then serves a registered read port to the renderer and clears
//   blocks on collision hits, tracking the live count and level-clear.
// Ports:
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   load_start            : request a (re)load from ROM
//   load_busy / load_done : load in progress / one-cycle completion pulse
//   rom_addr / rom_q      : position ROM interface (one-clock latency)
//   rd_addr               : renderer read address
//   rd_data / rd_alive    : registered position field and alive flag
//   hit_valid / hit_addr  : collision hit report
//   hit_ready             : hits accepted (not loading)
//   alive_count           : number of live blocks
//   level_clear           : one-cycle pulse when the last block is hit
module block_state_ram
   import block_state_ram_pkg::*;
#(
   parameter int unsigned WIDTH      = DEFAULT_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_start,
   output logic                  load_busy,
   output logic                  load_done,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [WIDTH-1:0]      rom_q,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-2:0]      rd_data,
   output logic                  rd_alive,
   input  logic                  hit_valid,
   input  logic [ADDR_WIDTH-1:0] hit_addr,
   output logic                  hit_ready,
   output logic [ADDR_WIDTH:0]   alive_count,
   output logic                  level_clear
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned CW    = ADDR_WIDTH + 1;
   localparam int unsigned AB    = alive_bit(WIDTH);

   logic [WIDTH-2:0]      r_mem [DEPTH];
   logic [DEPTH-1:0]      r_alive;
   logic [CW-1:0]         r_count;
   logic                  r_level_clear;
   logic [WIDTH-2:0]      r_rd_data;
   logic                  r_rd_alive;

   logic                  w_clear;
   logic                  w_cap_valid;
   logic [ADDR_WIDTH-1:0] w_cap_addr;
   logic                  w_busy;
   logic                  w_done;
   logic                  w_hit_acc;

   block_load_fsm #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_load_fsm (
      .clk         (clk),
      .reset       (reset),
      .i_start     (load_start),
      .o_rom_addr  (rom_addr),
      .o_clear     (w_clear),
      .o_cap_valid (w_cap_valid),
      .o_cap_addr  (w_cap_addr),
      .o_busy      (w_busy),
      .o_done      (w_done)
   );

   // A hit only counts on a live block; the count guard keeps the
   // counter from wrapping even if the vector and count ever disagree.
   assign w_hit_acc = hit_valid && !w_busy && r_alive[hit_addr] && (r_count != '0);

   // Position storage carries no reset.
   always_ff @(posedge clk) begin
      if (w_cap_valid) begin
         r_mem[w_cap_addr] <= rom_q[WIDTH-2:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_alive       <= '0;
         r_count       <= '0;
         r_level_clear <= 1'b0;
      end else begin
         r_level_clear <= 1'b0;
         if (w_clear) begin
            r_alive <= '0;
            r_count <= '0;
         end else if (w_cap_valid) begin
            r_alive[w_cap_addr] <= rom_q[AB];
            if (rom_q[AB]) begin
               r_count <= r_count + CW'(1);
            end
         end else if (w_hit_acc) begin
            r_alive[hit_addr] <= 1'b0;
            r_count           <= r_count - CW'(1);
            if (r_count == CW'(1)) begin
               r_level_clear <= 1'b1;
            end
         end
      end
   end

   // Read port samples pre-hit state, so a same-cycle hit shows next read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_data  <= '0;
         r_rd_alive <= 1'b0;
      end else begin
         r_rd_data  <= r_mem[rd_addr];
         r_rd_alive <= r_alive[rd_addr];
      end
   end

   assign rd_data     = r_rd_data;
   // Gated combinationally so nothing is drawn from the very first busy cycle.
   assign rd_alive    = r_rd_alive && !w_busy;
   assign load_busy   = w_busy;
   assign load_done   = w_done;
   assign hit_ready   = !w_busy;
   assign alive_count = r_count;
   assign level_clear = r_level_clear;

endmodule
